out_mem_sequencer: RTL and testbench
====================================

OUT_MEM_SEQUENCER -- requirements
Module: out_mem_sequencer

Interface
REQ-001 Parameter ADDR_W, 13, output-memory address width.
REQ-002 Parameter ROW_LEN, 7, write cycles per CONV output row (>=1).
REQ-003 Parameter RELU_LAT, 3, consecutive relu_activate cycles before writing starts (>=1).
REQ-004 Parameter POOL_DEPTH, 4, lanes packed per address word when pooling (power of 2, >=2).
REQ-005 Port clk  in  1  sole clock, rising edge.
REQ-006 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 Port conv_or_fc  in  2  mode: 2'b00 CONV, 2'b01 FC, 2'b1x reserved.
REQ-008 Port pool_en  in  1  pooled-packing mode.
REQ-009 Port relu_activate  in  1  ReLU stage producing valid data.
REQ-010 Port dram_access_required  in  1  flush buffer to DRAM after the current burst.
REQ-011 Port dram_ack  in  1  DRAM engine has consumed the buffer.
REQ-012 Port out_mem_addr  out  ADDR_W  write address.
REQ-013 Port en_out_mem / wen_out_mem  out  1 each  memory enable / write enable.
REQ-014 Port pool_lane  out  clog2(POOL_DEPTH)  lane within the packed word.
REQ-015 Port out_buf_ready  out  1  buffer ready for DRAM; held until dram_ack.
REQ-016 Port row_done  out  1  one-cycle pulse on the last write of a burst.
REQ-017 Port addr_overflow  out  1  sticky: address wrapped since last flush.

Function
REQ-018 States: IDLE, WRITE, DRAM_REQ; all outputs decoded from registers, no combinational input-to-output path.
REQ-019 IDLE: latency counter increments each cycle relu_activate=1 and mode is not reserved; clears when relu_activate=0.
REQ-020 IDLE -> WRITE when counter reaches RELU_LAT-1 with relu_activate=1; first write occurs RELU_LAT+1 cycles after relu_activate rises.
REQ-021 conv_or_fc and pool_en are latched on WRITE entry and held for the whole burst.
REQ-022 Burst length: ROW_LEN write cycles in CONV, 1 in FC; en_out_mem=wen_out_mem=1 exactly in WRITE.
REQ-023 pool_en=0: out_mem_addr increments after every write; pool_lane stays 0.
REQ-024 pool_en=1: pool_lane increments per write; address increments when lane wraps from POOL_DEPTH-1 to 0.
REQ-025 Burst end with pool_en=1 and partial word (lane != 0 after last write): address advances by one, lane resets to 0; next burst starts on a fresh word.
REQ-026 Last burst write: row_done=1; next state DRAM_REQ if dram_access_required=1 that cycle, else IDLE.
REQ-027 DRAM_REQ: out_buf_ready=1 until dram_ack=1 is sampled in DRAM_REQ; then address, lane and addr_overflow clear and state -> IDLE.
REQ-028 dram_ack outside DRAM_REQ is ignored; relu_activate during DRAM_REQ is ignored and does not count toward latency.
REQ-029 Address arithmetic modulo 2^ADDR_W; increment from all-ones gives 0 and sets addr_overflow.
REQ-030 Reserved mode: block stays in IDLE, no writes.

Reset
REQ-031 rst_n=0 at any time, including mid-burst or in DRAM_REQ: state IDLE, counters, address, lane 0, all outputs 0, asynchronously.
REQ-032 First write after reset release requires a full RELU_LAT qualification.

Structure
REQ-033 Shared package holds state encoding and mode constants (CONV, FC).
REQ-034 One sub-module, out_addr_packer: address/lane counter with partial-word flush and overflow flag.

Verification
REQ-035 Defaults, CONV, pool_en=0, relu_activate held 3 cycles, no DRAM: 7 writes at addresses 0..6, row_done on address 6, next row starts at 7.
REQ-036 CONV, pool_en=1, two rows: row 1 lanes 0,1,2,3 @0 then 0,1,2 @1; row 2 starts at address 2, lane 0.
REQ-037 FC, dram_access_required=1, dram_ack delayed 5 cycles: one write @0, out_buf_ready high 5 cycles, address 0 after ack.
REQ-038 relu_activate pulses 2 cycles high, 1 low, then 3 high: no write until the 3-cycle run completes.
REQ-039 ADDR_W=4, CONV, 3 rows without flush: address wraps 15->0, addr_overflow=1 until dram_ack.
REQ-040 rst_n asserted mid-burst at 4th write: outputs 0 immediately; subsequent burst restarts at address 0.

Source files
------------

// File: rtl/out_mem_sequencer_pkg.sv
// Shared types and constants for the output-memory write sequencer.
package out_mem_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WRITE    = 2'd1,
    ST_DRAM_REQ = 2'd2
  } state_t;

  localparam logic [1:0] MODE_CONV = 2'b00;
  localparam logic [1:0] MODE_FC   = 2'b01;

  // Modes 2'b1x are reserved and never start a burst.
  function automatic logic mode_valid(input logic [1:0] mode);
    return ~mode[1];
  endfunction

endpackage

// File: rtl/out_addr_packer.sv
// Output-memory address/lane counter with pooled-lane packing,
// partial-word flush at burst end and a sticky wrap flag.
module out_addr_packer #(
  parameter int unsigned ADDR_W     = 13,
  parameter int unsigned POOL_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          step,
  input  logic                          last,
  input  logic                          pool,
  input  logic                          clear,
  output logic [ADDR_W-1:0]             addr,
  output logic [$clog2(POOL_DEPTH)-1:0] lane,
  output logic                          overflow
);

  localparam int unsigned LANE_W = $clog2(POOL_DEPTH);

  logic [LANE_W-1:0] lane_inc;
  logic [LANE_W-1:0] lane_n;
  logic              adv;
  logic              wrap;

  // POOL_DEPTH is a power of two, so lane+1 wraps to 0 on its own.
  // The last pooled write always moves to a fresh word.
  always_comb begin
    lane_inc = lane + LANE_W'(1);
    lane_n   = lane;
    adv      = 1'b0;
    if (step) begin
      if (pool) begin
        adv    = (lane_inc == '0) || last;
        lane_n = last ? '0 : lane_inc;
      end else begin
        adv    = 1'b1;
        lane_n = '0;
      end
    end
    wrap = adv && (addr == '1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= '0;
      lane     <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      addr     <= '0;
      lane     <= '0;
      overflow <= 1'b0;
    end else begin
      addr <= addr + ADDR_W'(adv);
      lane <= lane_n;
      if (wrap) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/out_mem_sequencer.sv
// Sequences output-memory write bursts after a ReLU latency qualification,
// then optionally hands the buffer to the DRAM engine.
module out_mem_sequencer
  import out_mem_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W     = 13,
  parameter int unsigned ROW_LEN    = 7,
  parameter int unsigned RELU_LAT   = 3,
  parameter int unsigned POOL_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    conv_or_fc,
  input  logic                          pool_en,
  input  logic                          relu_activate,
  input  logic                          dram_access_required,
  input  logic                          dram_ack,
  output logic [ADDR_W-1:0]             out_mem_addr,
  output logic                          en_out_mem,
  output logic                          wen_out_mem,
  output logic [$clog2(POOL_DEPTH)-1:0] pool_lane,
  output logic                          out_buf_ready,
  output logic                          row_done,
  output logic                          addr_overflow
);

  localparam int unsigned LANE_W = $clog2(POOL_DEPTH);
  localparam int unsigned LAT_W  = (RELU_LAT > 1) ? $clog2(RELU_LAT) : 1;
  localparam int unsigned BEAT_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;

  state_t            state, state_n;
  logic [LAT_W-1:0]  lat_cnt, lat_n;
  logic [BEAT_W-1:0] beat, beat_n;
  logic [1:0]        mode_q, mode_n;
  logic              pool_q, pool_n;
  logic              step, last, clear, burst_last;

  logic [ADDR_W-1:0] addr;
  logic [LANE_W-1:0] lane;
  logic              overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      lat_cnt <= '0;
      beat    <= '0;
      mode_q  <= MODE_CONV;
      pool_q  <= 1'b0;
    end else begin
      state   <= state_n;
      lat_cnt <= lat_n;
      beat    <= beat_n;
      mode_q  <= mode_n;
      pool_q  <= pool_n;
    end
  end

  // Mode and pooling are captured on burst entry and held for the burst.
  always_comb begin
    state_n    = state;
    lat_n      = lat_cnt;
    beat_n     = beat;
    mode_n     = mode_q;
    pool_n     = pool_q;
    step       = 1'b0;
    last       = 1'b0;
    clear      = 1'b0;
    burst_last = (mode_q == MODE_FC) || (beat == BEAT_W'(ROW_LEN - 1));
    case (state)
      ST_IDLE: begin
        if (relu_activate && mode_valid(conv_or_fc)) begin
          if (lat_cnt == LAT_W'(RELU_LAT - 1)) begin
            state_n = ST_WRITE;
            lat_n   = '0;
            beat_n  = '0;
            mode_n  = conv_or_fc;
            pool_n  = pool_en;
          end else begin
            lat_n = lat_cnt + LAT_W'(1);
          end
        end else begin
          lat_n = '0;
        end
      end
      ST_WRITE: begin
        step   = 1'b1;
        last   = burst_last;
        beat_n = beat + BEAT_W'(1);
        if (burst_last) state_n = dram_access_required ? ST_DRAM_REQ : ST_IDLE;
      end
      ST_DRAM_REQ: begin
        if (dram_ack) begin
          clear   = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  out_addr_packer #(
    .ADDR_W     (ADDR_W),
    .POOL_DEPTH (POOL_DEPTH)
  ) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (step),
    .last     (last),
    .pool     (pool_q),
    .clear    (clear),
    .addr     (addr),
    .lane     (lane),
    .overflow (overflow)
  );

  // Output stage: every port is a flop fed from state-phase values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_mem_addr  <= '0;
      en_out_mem    <= 1'b0;
      wen_out_mem   <= 1'b0;
      pool_lane     <= '0;
      out_buf_ready <= 1'b0;
      row_done      <= 1'b0;
      addr_overflow <= 1'b0;
    end else begin
      out_mem_addr  <= addr;
      en_out_mem    <= (state == ST_WRITE);
      wen_out_mem   <= (state == ST_WRITE);
      pool_lane     <= lane;
      out_buf_ready <= (state == ST_DRAM_REQ);
      row_done      <= step && last;
      addr_overflow <= overflow;
    end
  end

endmodule

// File: tb/tb_out_mem_sequencer.sv
// Scoreboard bench for out_mem_sequencer: a default instance and a 4-bit
// address instance share stimulus; expected writes are queued per burst.
module tb_out_mem_sequencer;

  localparam int unsigned RELU_LAT   = 3;
  localparam int unsigned ROW_LEN    = 7;
  localparam int unsigned POOL_DEPTH = 4;
  localparam logic [1:0]  CONV = 2'b00;
  localparam logic [1:0]  FC   = 2'b01;

  logic        clk, rst_n;
  logic [1:0]  conv_or_fc;
  logic        pool_en, relu_activate, dram_access_required, dram_ack;

  logic [12:0] out_mem_addr;
  logic        en_out_mem, wen_out_mem, out_buf_ready, row_done, addr_overflow;
  logic [1:0]  pool_lane;

  logic [3:0]  addr4;
  logic        en4, wen4, ready4, rd4, ovf4;
  logic [1:0]  lane4;

  out_mem_sequencer dut (
    .clk(clk), .rst_n(rst_n), .conv_or_fc(conv_or_fc), .pool_en(pool_en),
    .relu_activate(relu_activate), .dram_access_required(dram_access_required),
    .dram_ack(dram_ack), .out_mem_addr(out_mem_addr), .en_out_mem(en_out_mem),
    .wen_out_mem(wen_out_mem), .pool_lane(pool_lane), .out_buf_ready(out_buf_ready),
    .row_done(row_done), .addr_overflow(addr_overflow)
  );

  out_mem_sequencer #(.ADDR_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .conv_or_fc(conv_or_fc), .pool_en(pool_en),
    .relu_activate(relu_activate), .dram_access_required(dram_access_required),
    .dram_ack(dram_ack), .out_mem_addr(addr4), .en_out_mem(en4),
    .wen_out_mem(wen4), .pool_lane(lane4), .out_buf_ready(ready4),
    .row_done(rd4), .addr_overflow(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int lane;
    int rd;
  } exp_t;

  exp_t q[$];
  exp_t q4[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int rise_cyc = 0;
  int first_wr_cyc = -1;
  int m_addr = 0;
  int m_lane = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n && en_out_mem) begin
      wr_cnt++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      check_eq("wr_expected", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check_eq("addr", 32'(out_mem_addr), 32'(e.addr));
        check_eq("lane", 32'(pool_lane), 32'(e.lane));
        check_eq("row_done", 32'(row_done), 32'(e.rd));
        check_eq("wen", 32'(wen_out_mem), 1);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && en4) begin
      check_eq("wr4_expected", 32'(q4.size() != 0), 1);
      if (q4.size() != 0) begin
        e = q4.pop_front();
        check_eq("addr4", 32'(addr4), 32'(e.addr));
        check_eq("row_done4", 32'(rd4), 32'(e.rd));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Reference address model: plain walk, lane packing, fresh word after a pooled burst.
  task automatic push_burst(input logic [1:0] mode, input logic pool);
    exp_t e;
    int len = (mode == FC) ? 1 : ROW_LEN;
    for (int i = 0; i < len; i++) begin
      e.lane = m_lane;
      e.rd   = (i == len - 1) ? 1 : 0;
      e.addr = m_addr % 8192;
      q.push_back(e);
      e.addr = m_addr % 16;
      q4.push_back(e);
      if (pool) begin
        m_lane++;
        if (m_lane == POOL_DEPTH) begin
          m_lane = 0;
          m_addr++;
        end
      end else begin
        m_addr++;
      end
    end
    if (pool && m_lane != 0) begin
      m_addr++;
      m_lane = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_eq("rst_outs", 32'({en_out_mem, wen_out_mem, out_mem_addr, pool_lane,
                               out_buf_ready, row_done, addr_overflow}), 0);
    check_eq("rst_outs4", 32'({en4, wen4, addr4, lane4, ready4, rd4, ovf4}), 0);
    q.delete();
    q4.delete();
    m_addr = 0;
    m_lane = 0;
    relu_activate = 1'b0;
    dram_ack = 1'b0;
    dram_access_required = 1'b0;
    conv_or_fc = CONV;
    pool_en = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Drives the qualification run, then scrambles mode/pool to prove they were latched.
  task automatic start_burst(input logic [1:0] mode, input logic pool, input logic dram,
                             input logic glitch);
    conv_or_fc = mode;
    pool_en = pool;
    dram_access_required = dram;
    first_wr_cyc = -1;
    push_burst(mode, pool);
    if (glitch) begin
      relu_activate = 1'b1;
      step();
      step();
      relu_activate = 1'b0;
      step();
    end
    relu_activate = 1'b1;
    rise_cyc = cyc;
    repeat (RELU_LAT) step();
    relu_activate = 1'b0;
    conv_or_fc = (mode == CONV) ? FC : CONV;
    pool_en = ~pool;
  endtask

  task automatic run_burst(input logic [1:0] mode, input logic pool, input logic dram,
                           input logic glitch);
    start_burst(mode, pool, dram, glitch);
    for (int i = 0; i < 80 && (q.size() != 0 || q4.size() != 0); i++) step();
    check_eq("drain", 32'(q.size() + q4.size()), 0);
    check_eq("latency", 32'(first_wr_cyc - rise_cyc), 32'(RELU_LAT + 1));
  endtask

  // Ack lands in the 5th DRAM_REQ cycle; relu pulses meanwhile must not qualify a burst.
  task automatic dram_handshake();
    int n;
    int base = wr_cnt;
    for (int i = 0; i < 20 && !out_buf_ready; i++) step();
    check_eq("ready_seen", 32'(out_buf_ready), 1);
    check_eq("ovf_pre", 32'(addr_overflow), 32'(m_addr > 8191));
    check_eq("ovf4_pre", 32'(ovf4), 32'(m_addr > 15));
    n = 1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (out_buf_ready) n++;
      dram_ack = (i == 3);
      relu_activate = (i <= 4);
    end
    check_eq("ready_cycles", 32'(n), 5);
    check_eq("no_wr_in_dram", 32'(wr_cnt - base), 0);
    dram_access_required = 1'b0;
    m_addr = 0;
    m_lane = 0;
    check_eq("addr_after_ack", 32'(out_mem_addr), 0);
    check_eq("addr4_after_ack", 32'(addr4), 0);
    check_eq("ovf4_after_ack", 32'(ovf4), 0);
  endtask

  initial begin
    int base;
    rst_n = 1'b1;
    relu_activate = 1'b0;
    dram_ack = 1'b0;
    dram_access_required = 1'b0;
    conv_or_fc = CONV;
    pool_en = 1'b0;
    #2;
    do_reset();

    // plain CONV rows, then a stray ack in IDLE
    run_burst(CONV, 1'b0, 1'b0, 1'b0);
    run_burst(CONV, 1'b0, 1'b0, 1'b0);
    dram_ack = 1'b1;
    step();
    dram_ack = 1'b0;
    step();
    step();
    check_eq("ack_ignored_idle", 32'(out_mem_addr), 32'(m_addr));

    // reserved mode never writes
    base = wr_cnt;
    conv_or_fc = 2'b10;
    relu_activate = 1'b1;
    repeat (8) step();
    relu_activate = 1'b0;
    repeat (4) step();
    check_eq("reserved_no_wr", 32'(wr_cnt - base), 0);

    // pooled packing, two rows
    do_reset();
    run_burst(CONV, 1'b1, 1'b0, 1'b0);
    run_burst(CONV, 1'b1, 1'b0, 1'b0);

    // interrupted relu qualification
    do_reset();
    run_burst(CONV, 1'b0, 1'b0, 1'b1);

    // FC write with DRAM flush
    do_reset();
    run_burst(FC, 1'b0, 1'b1, 1'b0);
    dram_handshake();
    run_burst(FC, 1'b0, 1'b0, 1'b0);

    // 4-bit address wrap across three rows
    do_reset();
    run_burst(CONV, 1'b0, 1'b0, 1'b0);
    run_burst(CONV, 1'b0, 1'b0, 1'b0);
    run_burst(CONV, 1'b0, 1'b1, 1'b0);
    dram_handshake();

    // reset during the 4th write of a burst
    do_reset();
    base = wr_cnt;
    start_burst(CONV, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40 && wr_cnt < base + 4; i++) step();
    check_eq("mid_reached", 32'(wr_cnt - base), 4);
    do_reset();
    run_burst(CONV, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
